// File: rtl/uart_pkg.sv
// Shared UART constants and FSM state encoding.
// Used by uart_rx and its companion transmitter.
package uart_pkg;

   localparam int DATA_BITS        = 8;
   localparam int CLKS_PER_BIT_DEF = 10417;

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] START = 3'd1;
   localparam logic [2:0] DATA  = 3'd2;
   localparam logic [2:0] STOP  = 3'd3;
   localparam logic [2:0] BREAK = 3'd4;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input.
// Reset value is a parameter so idle-high lines start inactive.
module sync_2ff #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, done strobe, framing error,
// and a BREAK state that waits out a held-low line.
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
   parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   output logic [7:0] data,
   output logic       done,
   output logic       busy,
   output logic       frame_err
);

   localparam logic [CNT_W-1:0] HALF_M1 =
      CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] BIT_M1 =
      CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

   logic [2:0]           state;
   logic [CNT_W-1:0]     cnt;
   logic [2:0]           idx;
   logic [DATA_BITS-1:0] shreg;
   logic                 rx_s;

   sync_2ff #(
      .RST_VAL (1'b1)
   ) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (rx),
      .q     (rx_s)
   );

   assign busy = (state != IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         idx       <= '0;
         shreg     <= '0;
         data      <= '0;
         done      <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         done      <= 1'b0;
         frame_err <= 1'b0;
         case (state)
            IDLE: begin
               cnt <= '0;
               if (!rx_s)
                  state <= START;
            end
            START: begin
               if (cnt == HALF_M1) begin
                  cnt   <= '0;
                  idx   <= '0;
                  // high at mid start bit is a glitch
                  state <= rx_s ? IDLE : DATA;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DATA: begin
               if (cnt == BIT_M1) begin
                  cnt        <= '0;
                  shreg[idx] <= rx_s;
                  if (idx == LAST_BIT)
                     state <= STOP;
                  else
                     idx <= idx + 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            STOP: begin
               if (cnt == BIT_M1) begin
                  cnt <= '0;
                  if (rx_s) begin
                     data  <= shreg;
                     done  <= 1'b1;
                     state <= IDLE;
                  end else begin
                     frame_err <= 1'b1;
                     state     <= BREAK;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            BREAK: begin
               if (rx_s)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Randomized self-checking bench for uart_rx against a frame-level
// model: queues of expected bytes and framing-error counts.
module tb_uart_rx;

   localparam int C    = 16;
   localparam int LAT  = 2 + C / 2 + 9 * C;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       rx = 1'b1;
   logic [7:0] data;
   logic       done;
   logic       busy;
   logic       frame_err;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [7:0] got_q[$];
   int         got_t[$];
   int         ferr_cnt = 0;
   int         viol = 0;
   logic       prev_done = 1'b0;
   logic       prev_ferr = 1'b0;

   int   last_fall;
   logic busy_mid;
   logic busy_hold;

   uart_rx #(
      .CLKS_PER_BIT (C)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .rx        (rx),
      .data      (data),
      .done      (done),
      .busy      (busy),
      .frame_err (frame_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (done) begin
         got_q.push_back(data);
         got_t.push_back(cyc);
      end
      if (frame_err) ferr_cnt++;
      if (done && frame_err) viol++;
      if (done && prev_done) viol++;
      if (frame_err && prev_ferr) viol++;
      prev_done = done;
      prev_ferr = frame_err;
   end

   task automatic clear_mon();
      got_q.delete();
      got_t.delete();
      ferr_cnt = 0;
   endtask

   task automatic idle(input int n);
      rx = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] b,
                             input logic stopb,
                             input int extra_low);
      rx = 1'b0;
      last_fall = cyc;
      repeat (C) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (C) @(negedge clk);
         if (i == 4) busy_mid = busy;
      end
      rx = stopb;
      repeat (C) @(negedge clk);
      if (!stopb) begin
         rx = 1'b0;
         repeat (extra_low) @(negedge clk);
         busy_hold = busy;
      end
      rx = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      total++;
      if (data !== 8'h00) begin
         bad++;
         $display("FAIL reset_data got=%h exp=00", data);
      end
      total++;
      if (done !== 1'b0 || frame_err !== 1'b0) begin
         bad++;
         $display("FAIL reset_pulses done=%b ferr=%b exp=0 0",
                  done, frame_err);
      end
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_busy got=%b exp=0", busy);
      end
      reset = 1'b0;
      idle(4);
   endtask

   task automatic check_one(input string nm,
                            input logic [7:0] b);
      int lat;
      total++;
      if (got_q.size() != 1) begin
         bad++;
         $display("FAIL %s_count got=%0d exp=1",
                  nm, got_q.size());
      end else begin
         total++;
         if (got_q[0] !== b) begin
            bad++;
            $display("FAIL %s_data got=%h exp=%h",
                     nm, got_q[0], b);
         end
         lat = got_t[0] - last_fall;
         total++;
         if (lat < LAT - 2 || lat > LAT + 2) begin
            bad++;
            $display("FAIL %s_latency got=%0d exp=%0d",
                     nm, lat, LAT);
         end
      end
      total++;
      if (ferr_cnt != 0) begin
         bad++;
         $display("FAIL %s_ferr got=%0d exp=0", nm, ferr_cnt);
      end
      total++;
      if (busy_mid !== 1'b1 || busy !== 1'b0) begin
         bad++;
         $display("FAIL %s_busy mid=%b end=%b exp=1 0",
                  nm, busy_mid, busy);
      end
      total++;
      if (data !== b) begin
         bad++;
         $display("FAIL %s_hold got=%h exp=%h", nm, data, b);
      end
   endtask

   task automatic test_basic();
      logic [7:0] b;
      for (int n = 0; n < 4; n++) begin
         b = (n == 0) ? 8'hA9 : 8'($urandom);
         clear_mon();
         send_frame(b, 1'b1, 0);
         idle(C);
         check_one("basic", b);
      end
   endtask

   task automatic test_glitch();
      logic [7:0] prev;
      prev = data;
      clear_mon();
      rx = 1'b0;
      repeat (4) @(negedge clk);
      rx = 1'b1;
      repeat (C / 2 + 3) @(negedge clk);
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL glitch_busy got=%b exp=0", busy);
      end
      idle(C);
      total++;
      if (got_q.size() != 0 || ferr_cnt != 0) begin
         bad++;
         $display("FAIL glitch_pulses done=%0d ferr=%0d exp=0 0",
                  got_q.size(), ferr_cnt);
      end
      total++;
      if (data !== prev) begin
         bad++;
         $display("FAIL glitch_data got=%h exp=%h", data, prev);
      end
   endtask

   task automatic test_break();
      logic [7:0] prev;
      prev = data;
      clear_mon();
      send_frame(8'h3C, 1'b0, 3 * C);
      total++;
      if (busy_hold !== 1'b1) begin
         bad++;
         $display("FAIL break_busy got=%b exp=1", busy_hold);
      end
      idle(6);
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL break_exit got=%b exp=0", busy);
      end
      total++;
      if (ferr_cnt != 1 || got_q.size() != 0) begin
         bad++;
         $display("FAIL break_pulses ferr=%0d done=%0d exp=1 0",
                  ferr_cnt, got_q.size());
      end
      total++;
      if (data !== prev) begin
         bad++;
         $display("FAIL break_data got=%h exp=%h", data, prev);
      end
      clear_mon();
      send_frame(8'h5A, 1'b1, 0);
      idle(C);
      check_one("after_break", 8'h5A);
   endtask

   task automatic test_back_to_back();
      clear_mon();
      send_frame(8'h55, 1'b1, 0);
      send_frame(8'hFF, 1'b1, 0);
      idle(2 * C);
      total++;
      if (got_q.size() != 2) begin
         bad++;
         $display("FAIL b2b_count got=%0d exp=2", got_q.size());
      end else begin
         total++;
         if (got_q[0] !== 8'h55 || got_q[1] !== 8'hFF) begin
            bad++;
            $display("FAIL b2b_data got=%h,%h exp=55,ff",
                     got_q[0], got_q[1]);
         end
         total++;
         if (got_t[1] - got_t[0] < 10 * C - 1 ||
             got_t[1] - got_t[0] > 10 * C + 1) begin
            bad++;
            $display("FAIL b2b_gap got=%0d exp=%0d",
                     got_t[1] - got_t[0], 10 * C);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] b;
      b = 8'hC3;
      clear_mon();
      rx = 1'b0;
      repeat (C) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         rx = b[i];
         repeat (C) @(negedge clk);
      end
      rx = b[4];
      repeat (C / 2) @(negedge clk);
      reset = 1'b1;
      #2;
      total++;
      if (data !== 8'h00 || busy !== 1'b0 ||
          done !== 1'b0 || frame_err !== 1'b0) begin
         bad++;
         $display("FAIL midrst_out d=%h b=%b dn=%b fe=%b exp=0",
                  data, busy, done, frame_err);
      end
      @(negedge clk);
      rx = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      idle(8 * C);
      total++;
      if (got_q.size() != 0 || ferr_cnt != 0) begin
         bad++;
         $display("FAIL midrst_abort done=%0d ferr=%0d exp=0 0",
                  got_q.size(), ferr_cnt);
      end
      clear_mon();
      send_frame(8'h81, 1'b1, 0);
      idle(C);
      check_one("after_rst", 8'h81);
   endtask

   task automatic test_zero_ff();
      clear_mon();
      send_frame(8'h00, 1'b1, 0);
      idle(C);
      check_one("zero", 8'h00);
      clear_mon();
      send_frame(8'hFF, 1'b1, 0);
      idle(C);
      check_one("ones", 8'hFF);
   endtask

   task automatic test_random();
      logic [7:0] exp_q[$];
      logic [7:0] b;
      logic       good;
      int         exp_ferr;
      exp_ferr = 0;
      clear_mon();
      for (int n = 0; n < 12; n++) begin
         b = 8'($urandom);
         good = ($urandom_range(0, 3) != 0);
         send_frame(b, good, $urandom_range(0, 2 * C));
         if (good) begin
            exp_q.push_back(b);
            idle($urandom_range(0, 20));
         end else begin
            exp_ferr++;
            idle(C + $urandom_range(0, 20));
         end
      end
      idle(2 * C);
      total++;
      if (got_q.size() != exp_q.size()) begin
         bad++;
         $display("FAIL rand_count got=%0d exp=%0d",
                  got_q.size(), exp_q.size());
      end else begin
         foreach (exp_q[i]) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin
               bad++;
               $display("FAIL rand_data[%0d] got=%h exp=%h",
                        i, got_q[i], exp_q[i]);
            end
         end
      end
      total++;
      if (ferr_cnt != exp_ferr) begin
         bad++;
         $display("FAIL rand_ferr got=%0d exp=%0d",
                  ferr_cnt, exp_ferr);
      end
   endtask

   task automatic test_pulses();
      total++;
      if (viol != 0) begin
         bad++;
         $display("FAIL pulse_shape got=%0d exp=0", viol);
      end
   endtask

   initial begin
      busy_mid  = 1'b0;
      busy_hold = 1'b0;
      last_fall = 0;
      @(negedge clk);
      test_reset();
      test_basic();
      test_glitch();
      test_break();
      test_back_to_back();
      test_reset_mid();
      test_zero_ff();
      test_random();
      test_pulses();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver for 8N1 serial frames: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); line idles high.
- It is the receiving end of the link driven by the team's UART_TX.
- Default timing matches UART_TX: 100 MHz clk, 10417 clocks per bit (9600 baud).
- Presents each received byte on a parallel bus with a one-cycle done strobe and a framing-error flag.

Parameters:
- CLKS_PER_BIT, 10417: clk cycles per serial bit. Must be >= 4. Sims use 16 for speed.
- CNT_W, $clog2(CLKS_PER_BIT): width of the bit-period counter.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  asynchronous, active-high reset.
- rx  input  1  serial line, asynchronous to clk, idle high.
- data  output  8  last correctly framed byte; holds its value until the next valid frame.
- done  output  1  one-cycle pulse; data is valid and updated in the same cycle.
- busy  output  1  high whenever a frame is in progress (state != IDLE).
- frame_err  output  1  one-cycle pulse when the stop bit samples 0.

Behaviour:
- Reset (async, active-high) forces:
  - state = IDLE, counter = 0, bit index = 0, shift register = 0
  - data = 8'h00, done = 0, busy = 0, frame_err = 0
  - both synchronizer flops = 1 (idle line)
- Synchronizer:
  - rx passes through a 2-flop synchronizer; rx_s is its output.
  - All FSM decisions use rx_s only, so there is 2 cycles of input latency.
- FSM states: IDLE, START, DATA, STOP, BREAK.
- IDLE:
  - When rx_s == 0: go to START, counter = 0.
- START:
  - Count to CLKS_PER_BIT/2 - 1 (middle of the start bit).
  - If rx_s == 0 there: go to DATA, counter = 0, bit index = 0.
  - If rx_s == 1 there: glitch. Return to IDLE with no done and no frame_err.
- DATA:
  - At counter == CLKS_PER_BIT-1: sample rx_s into the shift register LSB first (bit index 0 is data[0]), then reset the counter.
  - After bit index 7 is sampled, go to STOP.
- STOP, sample at counter == CLKS_PER_BIT-1:
  - rx_s == 1: load data from the shift register, pulse done for one cycle, go to IDLE. IDLE is reached mid stop bit, so a back-to-back start bit is caught with no lost frame.
  - rx_s == 0: pulse frame_err for one cycle, leave data unchanged, no done, go to BREAK.
- BREAK:
  - Wait until rx_s == 1, then go to IDLE. This stops a held-low line or break condition from being decoded as false frames.
  - busy stays high in BREAK.
- Latency: done asserts 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles after the rx falling edge. Bench tolerance is ±2 cycles.
- done and frame_err are mutually exclusive and never asserted for more than one cycle.
- Reset mid-frame: outputs return to reset values immediately, and the partial byte is discarded.
- A change on rx while in DATA or STOP outside the sample point is ignored (single mid-bit sampling, no majority vote).
- Counter width is CNT_W. The counter never wraps: it is always cleared at each sample point.

Decomposition:
- Package uart_pkg holds:
  - the state enum encoding (IDLE=0, START=1, DATA=2, STOP=3, BREAK=4, 3 bits)
  - constants DATA_BITS=8 and default CLKS_PER_BIT=10417, shared with UART_TX
- Sub-module sync_2ff: parameterized reset value, set to 1 here. Reusable for other asynchronous inputs.

Test Plan (CLKS_PER_BIT=16 unless stated):
1. Drive a serial frame for 8'b10101001 (A9) → data=8'hA9, one done pulse, frame_err=0, busy high from start until the STOP sample. Repeat at CLKS_PER_BIT=10417, and loop rx from UART_TX with data=8'hA9, tx_en=1.
2. 4-cycle low glitch on idle rx → no done, no frame_err, busy returns to 0 within CLKS_PER_BIT/2+3 cycles, data unchanged.
3. Frame 8'h3C with stop bit driven 0, rx held low 3 bit times, then high → one frame_err pulse, no done, data keeps its previous value, FSM stays in BREAK until rx high, then a following 8'h5A frame is received correctly.
4. Back-to-back frames 8'h55 then 8'hFF with no idle gap → two done pulses exactly 10*CLKS_PER_BIT apart (±1), data 8'h55 then 8'hFF.
5. Assert reset during bit 4 of a 8'hC3 frame, release, then send 8'h81 → outputs all 0 during reset, no done for the aborted frame, then data=8'h81 with one done.
6. Frame 8'h00, then 8'hFF → data=8'h00 and 8'hFF respectively, confirming all-zero data is not mistaken for a break.
